// File: rtl/red_seq.sv
// Area-reduced byte-reduction unit: sums four sign-extended bytes through a single
// 4-bit adder slice over 12 cycles. The result is held on Sum and marked by a one-cycle done pulse.
module red_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        busy,
  output logic        done,
  output logic [15:0] Sum
);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  op_reg, op_next;
  logic [1:0]  nib_reg, nib_next;
  logic [11:0] acc_reg, acc_next;
  logic        carry_reg, carry_next;
  logic [31:0] opnd_reg, opnd_next;
  logic [15:0] sum_reg, sum_next;

  logic [11:0] opnd_ext [4];
  logic [11:0] opnd_sel;
  logic [3:0]  acc_nib, opnd_nib;
  logic        cin;
  logic [4:0]  slice;
  logic [11:0] acc_upd;

  // Bytes are packed in operand order, so op_reg indexes the byte directly.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ext
      assign opnd_ext[gi] = {{4{opnd_reg[8*gi+7]}}, opnd_reg[8*gi +: 8]};
    end
  endgenerate

  always_comb begin
    opnd_sel = opnd_ext[op_reg];
    acc_upd  = acc_reg;
    case (nib_reg)
      2'd0:    begin acc_nib = acc_reg[3:0];  opnd_nib = opnd_sel[3:0];  end
      2'd1:    begin acc_nib = acc_reg[7:4];  opnd_nib = opnd_sel[7:4];  end
      default: begin acc_nib = acc_reg[11:8]; opnd_nib = opnd_sel[11:8]; end
    endcase
    cin   = (nib_reg == 2'd0) ? 1'b0 : carry_reg;
    slice = {1'b0, acc_nib} + {1'b0, opnd_nib} + {4'b0000, cin};
    case (nib_reg)
      2'd0:    acc_upd[3:0]  = slice[3:0];
      2'd1:    acc_upd[7:4]  = slice[3:0];
      default: acc_upd[11:8] = slice[3:0];
    endcase
  end

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    nib_next   = nib_reg;
    acc_next   = acc_reg;
    carry_next = carry_reg;
    opnd_next  = opnd_reg;
    sum_next   = sum_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next = ADD;
          op_next    = 2'd0;
          nib_next   = 2'd0;
          acc_next   = 12'd0;
          carry_next = 1'b0;
          opnd_next  = {B[15:8], A[15:8], B[7:0], A[7:0]};
        end else begin
          state_next = IDLE;
        end
      end
      ADD: begin
        acc_next   = acc_upd;
        carry_next = slice[4];
        if (nib_reg == 2'd2) begin
          nib_next = 2'd0;
          if (op_reg == 2'd3) begin
            state_next = DONE;
            op_next    = 2'd0;
            sum_next   = {{4{acc_upd[11]}}, acc_upd};
          end else begin
            op_next = op_reg + 2'd1;
          end
        end else begin
          nib_next = nib_reg + 2'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      op_reg    <= 2'd0;
      nib_reg   <= 2'd0;
      acc_reg   <= 12'd0;
      carry_reg <= 1'b0;
      opnd_reg  <= 32'd0;
      sum_reg   <= 16'd0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      nib_reg   <= nib_next;
      acc_reg   <= acc_next;
      carry_reg <= carry_next;
      opnd_reg  <= opnd_next;
      sum_reg   <= sum_next;
    end
  end

  assign busy = (state_reg == ADD);
  assign done = (state_reg == DONE);
  assign Sum  = sum_reg;

endmodule

// File: tb/tb_red_seq.sv
// Scoreboard bench for red_seq: stimulus queues expected sums and done cycles,
// and a negedge monitor checks done, busy and Sum every cycle.
module tb_red_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] A = 16'd0;
  logic [15:0] B = 16'd0;
  logic        busy, done;
  logic [15:0] Sum;

  red_seq dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Sum(Sum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sum;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] held_sum = 16'd0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] ref_sum(input logic [15:0] a, input logic [15:0] b);
    logic signed [7:0] b0, b1, b2, b3;
    int s;
    b0 = a[7:0];
    b1 = b[7:0];
    b2 = a[15:8];
    b3 = b[15:8];
    s  = b0 + b1 + b2 + b3;
    return 16'(s);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // Monitor: expectations derive only from the queued (sum, done cycle) entries.
  always @(negedge clk) begin
    if (!rst) begin
      logic exp_done, exp_busy;
      exp_done = (q.size() > 0) && (cyc == q[0].cyc);
      exp_busy = (q.size() > 0) && (cyc >= q[0].cyc - 12) && (cyc < q[0].cyc);
      check("done", {15'd0, done}, {15'd0, exp_done});
      check("busy", {15'd0, busy}, {15'd0, exp_busy});
      if (exp_done) begin
        check("sum", Sum, q[0].sum);
        $display("result cyc=%0d Sum=%h expected=%h", cyc, Sum, q[0].sum);
        held_sum = q[0].sum;
        void'(q.pop_front());
      end else begin
        check("sum_held", Sum, held_sum);
        if (q.size() > 0 && cyc > q[0].cyc) void'(q.pop_front());
      end
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    @(posedge clk); #1;
    A = a; B = b; start = 1'b1;
    e.sum = ref_sum(a, b);
    e.cyc = cyc + 13;
    q.push_back(e);
    $display("start cyc=%0d A=%h B=%h expect=%h", cyc, a, b, e.sum);
    @(posedge clk); #1;
    start = 1'b0;
    A = 16'($urandom); B = 16'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL timeout cyc=%0d pending=%0d required=0", cyc, q.size());
      q.delete();
    end
  endtask

  task automatic run_held(input logic [15:0] a, input logic [15:0] b, input int n);
    exp_t e;
    @(posedge clk); #1;
    A = a; B = b; start = 1'b1;
    for (int i = 1; i <= n; i++) begin
      e.sum = ref_sum(a, b);
      e.cyc = cyc + 13 * i;
      q.push_back(e);
    end
    $display("held start cyc=%0d A=%h B=%h runs=%0d", cyc, a, b, n);
    repeat (13 * (n - 1) + 1) @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    run_op(16'h0101, 16'h0101); wait_idle();
    run_op(16'h7F7F, 16'h7F7F); wait_idle();
    run_op(16'h8080, 16'h8080); wait_idle();
    run_op(16'hFF01, 16'h01FF); wait_idle();
    run_op(16'hFFFF, 16'hFFFF); wait_idle();

    // start pulsed mid-operation must be ignored
    run_op(16'h0203, 16'h0405);
    repeat (3) @(posedge clk);
    #1 A = 16'hFFFF; B = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle();

    run_held(16'h0101, 16'h0000, 4);
    wait_idle();

    // reset in ADD cycle 6 abandons the run
    run_op(16'h1234, 16'h5678);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
    held_sum = 16'd0;
    $display("reset cyc=%0d", cyc);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    run_op(16'h0A0B, 16'hF0F1); wait_idle();

    for (int i = 0; i < 20; i++) begin
      run_op(16'($urandom), 16'($urandom));
      wait_idle();
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    // back-to-back: second start issued exactly in the DONE cycle
    for (int i = 0; i < 6; i++) begin
      run_op(16'($urandom), 16'($urandom));
      repeat (11) @(posedge clk);
      run_op(16'($urandom), 16'($urandom));
      wait_idle();
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
